// File: rtl/rv_regfile.sv
// rv_regfile: integer register file with two combinational read ports,
// a per-register pending scoreboard and optional write-to-read bypass.
module rv_regfile #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            iss,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     nbusy
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [AW:0]     nbusy_q;
    logic [AW:0]     nbusy_d;

    logic wr_en;
    logic iss_en;
    logic hit1;
    logic hit2;
    logic ihit1;
    logic ihit2;

    assign wr_en  = we && (waddr != '0);
    assign iss_en = iss && (iss_rd != '0);

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
            pend_d[waddr] = 1'b0;
        end
        // issue applied after the write-back clear so it wins a collision
        if (iss_en) begin
            pend_d[iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
        nbusy_d = '0;
        for (int i = 1; i < NREG; i++) begin
            nbusy_d = nbusy_d + {{AW{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q  <= '0;
            nbusy_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pend_q  <= pend_d;
            nbusy_q <= nbusy_d;
        end
    end

    assign hit1  = (BYPASS != 0) && wr_en && (waddr == raddr1);
    assign hit2  = (BYPASS != 0) && wr_en && (waddr == raddr2);
    assign ihit1 = iss_en && (iss_rd == raddr1);
    assign ihit2 = iss_en && (iss_rd == raddr2);

    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (!rst && (raddr1 != '0)) begin
            rdata1 = hit1 ? wdata : regs_q[raddr1];
            busy1  = pend_q[raddr1] && !(hit1 && !ihit1);
        end
    end

    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (!rst && (raddr2 != '0)) begin
            rdata2 = hit2 ? wdata : regs_q[raddr2];
            busy2  = pend_q[raddr2] && !(hit2 && !ihit2);
        end
    end

    assign nbusy = nbusy_q;

endmodule
